// File: rtl/qlf_clk_pkg.sv
// rtl/qlf_clk_pkg.sv - shared defaults and per-channel state type for the QLF clock dividers
package qlf_clk_pkg;

    localparam int NCH_DEF      = 4;
    localparam int DIV_W_DEF    = 8;
    localparam int DIV_INIT_DEF = 0;

    typedef struct packed {
        logic [DIV_W_DEF-1:0] act;
        logic [DIV_W_DEF-1:0] shd;
        logic                 pending;
        logic [DIV_W_DEF-1:0] cnt;
    } ch_state_t;

endpackage

// File: rtl/gclkbuff_div_ch.sv
// rtl/gclkbuff_div_ch.sv - one divider channel; Z flop built only with GCLKBUFF_DIV_ZOUT_EN
import qlf_clk_pkg::*;

module gclkbuff_div_ch #(
    parameter int               DIV_W    = DIV_W_DEF,
    parameter logic [DIV_W-1:0] DIV_INIT = '0
) (
    input  logic             C,
    input  logic             R,
    input  logic             EN,
    input  logic             LOAD,
    input  logic [DIV_W-1:0] DIV,
    output logic             BUSY,
    output logic             CE,
    output logic             Z
);

    logic [DIV_W-1:0] act;
    logic [DIV_W-1:0] shd;
    logic [DIV_W-1:0] cnt;
    logic             pending;
    logic             ce_q;
    logic             tc;
    logic [DIV_W-1:0] next_ratio;

    assign tc         = EN && (cnt == '0);
    assign next_ratio = pending ? shd : act;

    // Ratio changes only take effect at a reload point (idle or terminal count),
    // so every period is a whole period of either the old or the new ratio.
    always_ff @(posedge C) begin
        if (R) begin
            act     <= DIV_INIT;
            shd     <= DIV_INIT;
            cnt     <= DIV_INIT;
            pending <= 1'b0;
            ce_q    <= 1'b0;
        end else begin
            ce_q <= tc;
            if (!EN || tc) begin
                if (LOAD) begin
                    act <= DIV;
                    cnt <= DIV;
                end else begin
                    act <= next_ratio;
                    cnt <= next_ratio;
                end
                pending <= 1'b0;
            end else begin
                cnt <= cnt - DIV_W'(1);
                if (LOAD) begin
                    shd     <= DIV;
                    pending <= 1'b1;
                end
            end
        end
    end

    assign BUSY = pending;
    assign CE   = ce_q;

`ifdef GCLKBUFF_DIV_ZOUT_EN
    logic z_q;

    always_ff @(posedge C) begin
        if (R) begin
            z_q <= 1'b0;
        end else if (tc) begin
            z_q <= ~z_q;
        end
    end

    assign Z = z_q;
`else
    assign Z = 1'b0;
`endif

endmodule

// File: rtl/gclkbuff_div.sv
// rtl/gclkbuff_div.sv - NCH-channel clock-enable divider; GCLKBUFF_DIV_ZOUT_EN adds divided-clock outputs
import qlf_clk_pkg::*;

module gclkbuff_div #(
    parameter int NCH      = NCH_DEF,
    parameter int DIV_W    = DIV_W_DEF,
    parameter int DIV_INIT = DIV_INIT_DEF
) (
    input  logic                 C,
    input  logic                 R,
    input  logic [NCH-1:0]       EN,
    input  logic [NCH*DIV_W-1:0] DIV,
    input  logic [NCH-1:0]       LOAD,
    output logic [NCH-1:0]       BUSY,
    output logic [NCH-1:0]       CE,
    output logic [NCH-1:0]       Z
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        gclkbuff_div_ch #(
            .DIV_W    (DIV_W),
            .DIV_INIT (DIV_W'(DIV_INIT))
        ) u_ch (
            .C    (C),
            .R    (R),
            .EN   (EN[i]),
            .LOAD (LOAD[i]),
            .DIV  (DIV[i*DIV_W +: DIV_W]),
            .BUSY (BUSY[i]),
            .CE   (CE[i]),
            .Z    (Z[i])
        );
    end

endmodule

// File: tb/tb_gclkbuff_div.sv
// tb/tb_gclkbuff_div.sv - scoreboard bench for gclkbuff_div (expects Z toggling only with GCLKBUFF_DIV_ZOUT_EN)
module tb_gclkbuff_div;

    localparam int NCH   = 4;
    localparam int DIV_W = 8;

    logic                 C = 1'b0;
    logic                 R = 1'b1;
    logic [NCH-1:0]       EN = '0;
    logic [NCH*DIV_W-1:0] DIV = '0;
    logic [NCH-1:0]       LOAD = '0;
    logic [NCH-1:0]       BUSY;
    logic [NCH-1:0]       CE;
    logic [NCH-1:0]       Z;

    gclkbuff_div #(.NCH(NCH), .DIV_W(DIV_W), .DIV_INIT(2)) dut (
        .C(C), .R(R), .EN(EN), .DIV(DIV), .LOAD(LOAD),
        .BUSY(BUSY), .CE(CE), .Z(Z)
    );

    always #5 C = ~C;

    typedef struct {
        int   t;
        int   ch;
        logic z;
    } ev_t;

    ev_t            q[$];
    int             cyc = 0;
    int             n_cmp = 0;
    int             n_err = 0;
    logic [NCH-1:0] zexp = '0;

    always @(posedge C) cyc <= cyc + 1;

    function automatic logic zmodel(input int ch);
`ifdef GCLKBUFF_DIV_ZOUT_EN
        return zexp[ch];
`else
        return 1'b0;
`endif
    endfunction

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic exp_ce(input int ch, input int t);
        ev_t e;
        zexp[ch] = ~zexp[ch];
        e.t = t;
        e.ch = ch;
        e.z = zmodel(ch);
        q.push_back(e);
    endtask

    task automatic load_idle(input int ch, input int d);
        DIV[ch*DIV_W +: DIV_W] = DIV_W'(d);
        LOAD[ch] = 1'b1;
        tick();
        LOAD[ch] = 1'b0;
    endtask

    task automatic chk(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every CE strobe must match the next expected event in time, channel and Z.
    always @(negedge C) begin
        if (!R) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (CE[ch]) begin
                    n_cmp++;
                    if (q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_ce: ch %0d at cycle %0d, expected none", ch, cyc);
                    end else begin
                        ev_t e;
                        e = q.pop_front();
                        if (e.t != cyc || e.ch != ch || e.z !== Z[ch]) begin
                            n_err++;
                            $display("FAIL ce_event: got ch %0d cyc %0d z %b, expected ch %0d cyc %0d z %b",
                                     ch, cyc, Z[ch], e.ch, e.t, e.z);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int t0;

        // Reset
        tick();
        tick();
        R = 1'b0;
        chk("reset_ce", CE, '0);
        chk("reset_z", Z, '0);
        chk("reset_busy", BUSY, '0);
        t0 = cyc;
        EN[0] = 1'b1;
        exp_ce(0, t0 + 3);
        exp_ce(0, t0 + 6);
        wait_to(t0 + 6);
        EN[0] = 1'b0;

        // Divide-by-4 loaded while idle
        load_idle(0, 3);
        chk("div4_busy", BUSY, '0);
        t0 = cyc;
        EN[0] = 1'b1;
        exp_ce(0, t0 + 4);
        exp_ce(0, t0 + 8);
        exp_ce(0, t0 + 12);
        wait_to(t0 + 3);
        chk("div4_busy_run", BUSY, '0);
        wait_to(t0 + 12);
        EN[0] = 1'b0;

        // Mid-run load on channel 1
        load_idle(1, 5);
        t0 = cyc;
        EN[1] = 1'b1;
        exp_ce(1, t0 + 6);
        exp_ce(1, t0 + 8);
        exp_ce(1, t0 + 10);
        wait_to(t0 + 2);
        DIV[1*DIV_W +: DIV_W] = 8'd1;
        LOAD[1] = 1'b1;
        tick();
        LOAD[1] = 1'b0;
        chk("midload_busy_t3", BUSY, 4'b0010);
        wait_to(t0 + 5);
        chk("midload_busy_t5", BUSY, 4'b0010);
        tick();
        chk("midload_busy_t6", BUSY, 4'b0000);
        wait_to(t0 + 10);
        EN[1] = 1'b0;

        // Load coincident with terminal count: ratio 0 applied directly
        load_idle(2, 3);
        t0 = cyc;
        EN[2] = 1'b1;
        for (int k = 4; k <= 7; k++) exp_ce(2, t0 + k);
        wait_to(t0 + 3);
        DIV[2*DIV_W +: DIV_W] = 8'd0;
        LOAD[2] = 1'b1;
        tick();
        LOAD[2] = 1'b0;
        chk("coinc_busy", BUSY, '0);
        wait_to(t0 + 7);
        EN[2] = 1'b0;

        // Two loads while pending: last one wins
        load_idle(2, 4);
        t0 = cyc;
        EN[2] = 1'b1;
        exp_ce(2, t0 + 5);
        exp_ce(2, t0 + 8);
        exp_ce(2, t0 + 11);
        wait_to(t0 + 1);
        DIV[2*DIV_W +: DIV_W] = 8'd7;
        LOAD[2] = 1'b1;
        tick();
        DIV[2*DIV_W +: DIV_W] = 8'd2;
        tick();
        LOAD[2] = 1'b0;
        chk("overwrite_busy", BUSY, 4'b0100);
        wait_to(t0 + 11);
        EN[2] = 1'b0;

        // Ratio 0 with EN held for 5 cycles, then dropped
        load_idle(3, 0);
        t0 = cyc;
        EN[3] = 1'b1;
        for (int k = 1; k <= 5; k++) exp_ce(3, t0 + k);
        wait_to(t0 + 5);
        EN[3] = 1'b0;
        tick();
        chk("endrop_ce", CE, '0);
        chk("endrop_z_hold", {3'b000, Z[3]}, {3'b000, zmodel(3)});
        tick();
        chk("endrop_z_hold2", {3'b000, Z[3]}, {3'b000, zmodel(3)});

        // Reset in the middle of a pending load
        load_idle(2, 6);
        t0 = cyc;
        EN[2] = 1'b1;
        wait_to(t0 + 1);
        DIV[2*DIV_W +: DIV_W] = 8'd1;
        LOAD[2] = 1'b1;
        tick();
        LOAD[2] = 1'b0;
        chk("rst_mid_busy_pre", BUSY, 4'b0100);
        R = 1'b1;
        tick();
        R = 1'b0;
        chk("rst_mid_busy", BUSY, '0);
        chk("rst_mid_z", Z, '0);
        chk("rst_mid_ce", CE, '0);
        zexp = '0;
        exp_ce(2, t0 + 6);
        exp_ce(2, t0 + 9);
        wait_to(t0 + 9);
        EN[2] = 1'b0;

        repeat (4) tick();
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL missing_ce: %0d expected strobes never seen, expected 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
